// File: rtl/led_result_pkg.sv
// Shared types and constants for the reaction-timer LED result latch.
package led_result_pkg;

    localparam int DIG_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] MODE_LAST = 2'b00;
    localparam logic [1:0] MODE_BEST = 2'b01;
    localparam logic [1:0] MODE_HIST = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

endpackage

// File: rtl/led_result_hist.sv
// Circular history of captured results with a registered read port.
// Index 0 is the most recent entry. A read returns the contents as they were before a same-cycle push.
module led_hist_ring #(
    parameter int HIST = 4,
    parameter int W    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [W-1:0]            i_data,
    input  logic [$clog2(HIST)-1:0] i_idx,
    output logic [W-1:0]            o_rd_data,
    output logic                    o_rd_vld,
    output logic [$clog2(HIST):0]   o_cnt
);
    localparam int AW = $clog2(HIST);

    logic [W-1:0]  r_mem [HIST];
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_cnt;
    logic [W-1:0]  r_rd_data;
    logic          r_rd_vld;
    logic [AW-1:0] w_raddr;
    logic          w_hit;

    // HIST is a power of two, so the subtraction wraps for free.
    assign w_raddr = r_wptr - AW'(1) - i_idx;
    assign w_hit   = {1'b0, i_idx} < r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
                if (r_cnt != (AW+1)'(HIST))
                    r_cnt <= r_cnt + (AW+1)'(1);
            end
            r_rd_vld  <= w_hit;
            r_rd_data <= w_hit ? r_mem[w_raddr] : '0;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_rd_vld  = r_rd_vld;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/led_result_latch.sv
// Result latch and LED display driver: captures a non-zero BCD time per readit, tracks best, keeps history.
// Optional blinking new-best indicator when LED_RESULT_BLINK_EN is defined.
module led_result_latch
    import led_result_pkg::*;
#(
    parameter int NDIG      = 2,
    parameter int HIST      = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                    clk50M,
    input  logic                    rst_n,
    input  logic [DIG_W*NDIG-1:0]   digits,
    input  logic                    readit,
    input  logic [1:0]              mode,
    input  logic [$clog2(HIST)-1:0] hist_idx,
    output logic [DIG_W*NDIG+1:0]   LED,
    output logic [$clog2(HIST):0]   hist_cnt
);
    localparam int VW = DIG_W * NDIG;

    state_t        r_state;
    logic [VW-1:0] r_last;
    logic [VW-1:0] r_best;
    logic          r_best_vld;
    logic          r_nb;
    logic [VW+1:0] r_led;
    logic [1:0]    r_mode_q;
    logic          w_capture;
    logic          w_better;
    logic          w_nb_disp;
    logic [VW-1:0] w_hist_data;
    logic          w_hist_vld;

    // Zero means "no reaction yet" and is never latched.
    assign w_capture = (r_state == IDLE) && readit && (digits != '0);
    assign w_better  = !r_best_vld || (digits < r_best);

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= '0;
            r_best     <= '0;
            r_best_vld <= 1'b0;
            r_nb       <= 1'b0;
        end else if (!readit) begin
            r_state <= IDLE;
            r_last  <= '0;
            r_nb    <= 1'b0;
        end else if (w_capture) begin
            r_state <= HOLD;
            r_last  <= digits;
            r_nb    <= w_better;
            if (w_better) begin
                r_best     <= digits;
                r_best_vld <= 1'b1;
            end
        end
    end

`ifdef LED_RESULT_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (w_capture) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_state == HOLD) begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_nb_disp = r_nb & r_blink_on;
`else
    assign w_nb_disp = r_nb;
`endif

    led_hist_ring #(
        .HIST (HIST),
        .W    (VW)
    ) u_hist (
        .i_clk     (clk50M),
        .i_rst_n   (rst_n),
        .i_push    (w_capture),
        .i_data    (digits),
        .i_idx     (hist_idx),
        .o_rd_data (w_hist_data),
        .o_rd_vld  (w_hist_vld),
        .o_cnt     (hist_cnt)
    );

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            r_led    <= '0;
            r_mode_q <= MODE_LAST;
        end else begin
            r_mode_q <= mode;
            case (mode)
                MODE_LAST: r_led <= {w_nb_disp, r_state == HOLD, r_last};
                MODE_BEST: r_led <= {1'b0, r_best_vld, r_best};
                default:   r_led <= '0;
            endcase
        end
    end

    // History data is already registered inside the ring; select it with the registered mode.
    assign LED = (r_mode_q == MODE_HIST) ? {1'b0, w_hist_vld, w_hist_data} : r_led;

endmodule

// File: tb/tb_led_result_latch.sv
// Directed self-checking bench for led_result_latch (NDIG=2, HIST=4, BLINK_DIV=4).
module tb_led_result_latch;

    logic       clk50M = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] digits = '0;
    logic       readit = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic [1:0] hist_idx = '0;
    logic [9:0] LED;
    logic [2:0] hist_cnt;

    int checks = 0;
    int errors = 0;

    led_result_latch #(.NDIG(2), .HIST(4), .BLINK_DIV(4)) dut (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .digits   (digits),
        .readit   (readit),
        .mode     (mode),
        .hist_idx (hist_idx),
        .LED      (LED),
        .hist_cnt (hist_cnt)
    );

    always #5 clk50M = ~clk50M;

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    // One-cycle readit pulse; leaves the bench one edge after the capture edge.
    task automatic pulse(input logic [7:0] d);
        digits = d; readit = 1'b1;
        tick();
        readit = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; readit = 1'b0; digits = '0; mode = 2'b00; hist_idx = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL reset_led got %h want %h", LED, 10'h000); end
        checks++;
        if (hist_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", hist_cnt); end
    endtask

    task automatic test_capture();
        readit = 1'b1; digits = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (LED !== 10'h000) begin errors++; $display("FAIL zero_hold[%0d] got %h want %h", i, LED, 10'h000); end
        end
        digits = 8'h37;
        tick(); tick();
        checks++;
        if (LED !== 10'b11_0011_0111) begin errors++; $display("FAIL first_cap got %b want %b", LED, 10'b11_0011_0111); end
        digits = 8'h12;
        tick(); tick();
        checks++;
        if (LED !== 10'h337) begin errors++; $display("FAIL hold_frozen got %h want %h", LED, 10'h337); end
        readit = 1'b0;
        tick(); tick();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL release got %h want %h", LED, 10'h000); end
        mode = 2'b01;
        tick();
        checks++;
        if (LED !== 10'h137) begin errors++; $display("FAIL best_view got %h want %h", LED, 10'h137); end
        mode = 2'b11;
        tick();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL mode_off got %h want %h", LED, 10'h000); end
        mode = 2'b00;
    endtask

    task automatic test_best();
        logic [7:0] vals [4] = '{8'h37, 8'h45, 8'h21, 8'h21};
        logic       nb   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            digits = vals[i]; readit = 1'b1;
            tick(); readit = 1'b0; tick();
            checks++;
            if (LED !== {nb[i], 1'b1, vals[i]})
                begin errors++; $display("FAIL newbest[%0d] got %h want %h", i, LED, {nb[i], 1'b1, vals[i]}); end
        end
        mode = 2'b01;
        tick();
        checks++;
        if (LED !== 10'h121) begin errors++; $display("FAIL best_min got %h want %h", LED, 10'h121); end
        mode = 2'b00;
    endtask

    task automatic test_history();
        logic [7:0] exp_h [4] = '{8'h16, 8'h15, 8'h14, 8'h13};
        do_reset();
        mode = 2'b10; hist_idx = 2'd0;
        tick();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL hist_empty got %h want %h", LED, 10'h000); end
        pulse(8'h11);
        hist_idx = 2'd1;
        tick();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL hist_idx_oob got %h want %h", LED, 10'h000); end
        for (int i = 2; i <= 6; i++) pulse(8'h10 + 8'(i));
        checks++;
        if (hist_cnt !== 3'd4) begin errors++; $display("FAIL hist_cnt_sat got %0d want 4", hist_cnt); end
        for (int i = 0; i < 4; i++) begin
            hist_idx = 2'(i);
            tick();
            checks++;
            if (LED !== {2'b01, exp_h[i]})
                begin errors++; $display("FAIL hist_rd[%0d] got %h want %h", i, LED, {2'b01, exp_h[i]}); end
        end
        // Same-cycle capture and read: the old head first, the new entry one cycle later.
        hist_idx = 2'd0;
        tick();
        digits = 8'h17; readit = 1'b1;
        tick();
        checks++;
        if (LED !== 10'h116) begin errors++; $display("FAIL hist_prewrite got %h want %h", LED, 10'h116); end
        readit = 1'b0;
        tick();
        checks++;
        if (LED !== 10'h117) begin errors++; $display("FAIL hist_postwrite got %h want %h", LED, 10'h117); end
        mode = 2'b00;
    endtask

    task automatic test_reset_in_hold();
        digits = 8'h09; readit = 1'b1;
        tick(); tick();
        checks++;
        if (LED !== 10'h309) begin errors++; $display("FAIL pre_rst_hold got %h want %h", LED, 10'h309); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (LED !== 10'h000 || hist_cnt !== 3'd0)
            begin errors++; $display("FAIL rst_in_hold got led=%h cnt=%0d want 000/0", LED, hist_cnt); end
        rst_n = 1'b1; readit = 1'b0; mode = 2'b01;
        tick();
        checks++;
        if (LED !== 10'h000) begin errors++; $display("FAIL best_cleared got %h want %h", LED, 10'h000); end
        mode = 2'b00;
    endtask

    task automatic test_blink();
        logic exp_nb;
        do_reset();
        digits = 8'h42; readit = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef LED_RESULT_BLINK_EN
            exp_nb = (((k - 1) / 4) % 2) == 0;
`else
            exp_nb = 1'b1;
`endif
            checks++;
            if (LED !== {exp_nb, 1'b1, 8'h42})
                begin errors++; $display("FAIL blink[%0d] got %h want %h", k, LED, {exp_nb, 1'b1, 8'h42}); end
        end
        readit = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_best();
        test_history();
        test_reset_in_hold();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_result_latch.md
# led_result_latch

Parametrised result latch and display driver for the reaction timer's LED bank. It captures an NDIG-digit BCD reaction time once per `readit` assertion and holds it until `readit` drops. It also tracks the best (lowest) time and keeps a circular history of the last HIST results. It sits between the timer/BCD counter and the board LEDs, and generalises the original two-nibble latch to N digits, a best-time register and selectable display modes.

## Interface
- `NDIG`, 2, number of 4-bit BCD digits captured.
- `HIST`, 4, history depth, ≥2, power of two.
- `BLINK_DIV`, 25_000_000, clk50M cycles per blink half-period; used only with the blink feature.
- `clk50M`  in  1  single system clock, all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `digits`  in  4*NDIG  BCD time, digit 0 in bits [3:0].
- `readit`  in  1  capture enable; low clears the live display.
- `mode`  in  2  00 = last, 01 = best, 10 = history entry, 11 = reserved.
- `hist_idx`  in  $clog2(HIST)  history entry; 0 = most recent.
- `LED`  out  4*NDIG+2  [4*NDIG-1:0] value, [4*NDIG] valid, [4*NDIG+1] new-best.
- `hist_cnt`  out  $clog2(HIST)+1  number of stored history entries.

## Operation
- FSM states:
  - IDLE: armed, live value cleared.
  - HOLD: value captured and frozen.
- IDLE, `readit`=1 and `digits`≠0:
  - `last`<=`digits`.
  - Push into history.
  - Compare against best.
  - Go to HOLD.
- IDLE, `readit`=1 and `digits`=0: stay in IDLE and keep re-sampling every cycle. A zero time is "no reaction yet" and is never captured.
- HOLD, `readit`=1: no further capture; input changes are ignored.
- `readit`=0 in any state:
  - Go to IDLE.
  - `last`<=0 and new-best flag cleared.
  - Best and history retained.
- Best compare:
  - Compare as an unsigned 4*NDIG-bit number; valid BCD orders correctly.
  - Update when no best exists yet, or `digits` < `best`. Equal does not update.
  - Set the new-best flag on update.
- History ring:
  - Write pointer wraps modulo HIST.
  - `hist_cnt` saturates at HIST; once full, the oldest entry is overwritten.
- Display mux, by `mode`:
  - 00: value = `last`, valid = (state==HOLD), new-best = flag.
  - 01: value = `best`, valid = best exists, new-best = 0.
  - 10: if `hist_idx` < `hist_cnt`, value = that entry with valid = 1; otherwise value 0 with valid = 0. New-best = 0.
  - 11: all LED bits 0.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `LED`=0, `hist_cnt`=0, state IDLE.
  - best invalid, `last`=0, write pointer 0, blink counter 0.
- Reset has priority over every other event, including mid-HOLD.
- `LED` is registered. A capture sampled at edge N is visible after edge N+1; latency is one cycle.
- `mode`/`hist_idx` changes are reflected one cycle later.
- A capture and a history read in the same cycle: the read returns the pre-write contents; the new entry appears the next cycle.
- `readit` falling while `digits`≠0 in IDLE: no capture.
- Assertion pulses of one cycle are sufficient for capture.

## Configuration
- Macro: `LED_RESULT_BLINK_EN`.
- Defined:
  - In mode 00 during HOLD with the flag set, the new-best bit toggles every BLINK_DIV cycles, starting lit on the capture cycle.
  - The counter is reset on each capture and by `rst_n`.
- Undefined: the new-best bit is steady and the blink counter is not instantiated.

## Structure
- Package `led_result_pkg`:
  - State enum (IDLE, HOLD).
  - Mode encodings (`MODE_LAST`, `MODE_BEST`, `MODE_HIST`, `MODE_OFF`).
  - Digit-width constant of 4.
- Sub-module `led_hist_ring`:
  - Parameters HIST and width.
  - Push input, read index, synchronous read, count output.
  - Same clock and reset.
- Top level holds the FSM, best register, display mux and optional blink counter.

## Test plan
- Reset then `readit`=1, `digits`=8'h00 for 5 cycles, then 8'h37:
  - LED stays 0 while digits are zero.
  - One cycle after 8'h37 is sampled, LED=10'b11_0011_0111 (first result is a new best).
- In HOLD, change `digits` to 8'h12:
  - LED unchanged.
  - `readit`=0 → LED=0 next cycle.
  - mode 01 → value 8'h37, valid 1.
- Captures 8'h37, 8'h45, 8'h21:
  - Best = 8'h21.
  - New-best bit set on 37 and 21, clear on 45.
  - Equal time 8'h21 again does not set it.
- HIST=4, six captures 8'h11..8'h16:
  - `hist_cnt`=4.
  - mode 10 with idx 0..3 → 16,15,14,13.
  - idx ≥ `hist_cnt` after reset → zeros, valid 0.
- `rst_n`=0 during HOLD:
  - Next cycle all outputs 0, best invalid, `hist_cnt`=0.
- With `LED_RESULT_BLINK_EN`, BLINK_DIV=4, new-best capture held:
  - New-best bit toggles every 4 cycles.
  - Without the macro it stays 1.
